// File: rtl/conv_tuser_gen.sv
// Sideband generator feeding the convolution pad filter: one config beat per frame, then pixel
// words annotated with tuser flags. Define CONV_TUSER_GEN_PERF_EN to enable the stall counter.
module conv_tuser_gen #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BITS_KW2   = 2,
    parameter int unsigned BITS_SW    = 2,
    parameter int unsigned BITS_CIN   = 10,
    parameter int unsigned BITS_COLS  = 10,
    parameter int unsigned BITS_ROWS  = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  aclken,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [BITS_KW2-1:0]   cfg_kw2,
    input  logic [BITS_SW-1:0]    cfg_sw_1,
    input  logic [BITS_CIN-1:0]   cfg_cin_1,
    input  logic [BITS_COLS-1:0]  cfg_cols_1,
    input  logic [BITS_ROWS-1:0]  cfg_rows_1,
    output logic                  cfg_err,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [BITS_KW2-1:0]   m_kw2,
    output logic [BITS_SW-1:0]    m_sw_1,
    output logic                  m_is_config,
    output logic                  m_is_cin_last,
    output logic                  m_is_cols_1_k2,
    output logic                  m_is_col_valid,
    output logic                  m_last,
    output logic [31:0]           perf_stall_cnt
);

    typedef enum logic [1:0] {StIdle, StConfig, StRun} state_e;

    state_e                 state_q, state_d;
    logic [BITS_KW2-1:0]    kw2_q, kw2_d;
    logic [BITS_SW-1:0]     sw_1_q, sw_1_d;
    logic [BITS_CIN-1:0]    cin_1_q, cin_1_d;
    logic [BITS_COLS-1:0]   cols_1_q, cols_1_d;
    logic [BITS_ROWS-1:0]   rows_1_q, rows_1_d;
    logic [BITS_COLS-1:0]   end_col_q, end_col_d;
    logic [BITS_CIN-1:0]    cin_cnt_q, cin_cnt_d;
    logic [BITS_COLS-1:0]   col_cnt_q, col_cnt_d;
    logic [BITS_ROWS-1:0]   row_cnt_q, row_cnt_d;
    logic [BITS_SW-1:0]     str_cnt_q, str_cnt_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [BITS_KW2-1:0]    m_kw2_q, m_kw2_d;
    logic [BITS_SW-1:0]     m_sw_1_q, m_sw_1_d;
    logic [4:0]             m_flags_q, m_flags_d;

    logic                   free;
    logic                   cfg_fire;
    logic                   cfg_bad;
    logic                   cfg_accept;
    logic                   s_fire;
    logic                   cin_max, col_max, row_max;
    logic [BITS_COLS-1:0]   cfg_kw2_ext;

    assign free        = !m_valid_q | m_ready;
    assign cfg_ready   = aclken & (state_q == StIdle);
    assign s_ready     = aclken & free & (state_q == StRun);
    assign cfg_fire    = cfg_valid & cfg_ready;
    assign s_fire      = s_valid & s_ready;
    assign cfg_kw2_ext = BITS_COLS'(cfg_kw2);
    assign cfg_bad     = cfg_cols_1 < cfg_kw2_ext;
    assign cfg_accept  = cfg_fire & !cfg_bad;
    assign cin_max     = cin_cnt_q == cin_1_q;
    assign col_max     = col_cnt_q == cols_1_q;
    assign row_max     = row_cnt_q == rows_1_q;

    always_comb begin
        state_d   = state_q;
        kw2_d     = kw2_q;
        sw_1_d    = sw_1_q;
        cin_1_d   = cin_1_q;
        cols_1_d  = cols_1_q;
        rows_1_d  = rows_1_q;
        end_col_d = end_col_q;
        cin_cnt_d = cin_cnt_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        str_cnt_d = str_cnt_q;
        cfg_err_d = cfg_err_q;
        m_valid_d = m_valid_q & !m_ready;
        m_data_d  = m_data_q;
        m_kw2_d   = m_kw2_q;
        m_sw_1_d  = m_sw_1_q;
        m_flags_d = m_flags_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_fire && cfg_bad) begin
                    cfg_err_d = 1'b1;
                end else if (cfg_fire) begin
                    cfg_err_d = 1'b0;
                    kw2_d     = cfg_kw2;
                    sw_1_d    = cfg_sw_1;
                    cin_1_d   = cfg_cin_1;
                    cols_1_d  = cfg_cols_1;
                    rows_1_d  = cfg_rows_1;
                    // Registered so the per-beat column compare has no subtractor in front of it
                    end_col_d = cfg_cols_1 - cfg_kw2_ext;
                    cin_cnt_d = '0;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
                    str_cnt_d = '0;
                    state_d   = StConfig;
                end
            end
            StConfig: begin
                if (free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = '0;
                    m_kw2_d   = kw2_q;
                    m_sw_1_d  = sw_1_q;
                    m_flags_d = 5'b10000;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (s_fire) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                    m_kw2_d   = kw2_q;
                    m_sw_1_d  = sw_1_q;
                    m_flags_d = {1'b0, cin_max, (col_cnt_q == end_col_q) && (kw2_q != '0),
                                 str_cnt_q == '0, cin_max & col_max & row_max};
                    if (!cin_max) begin
                        cin_cnt_d = cin_cnt_q + BITS_CIN'(1);
                    end else begin
                        cin_cnt_d = '0;
                        if (!col_max) begin
                            col_cnt_d = col_cnt_q + BITS_COLS'(1);
                            str_cnt_d = (str_cnt_q == sw_1_q) ? '0 : str_cnt_q + BITS_SW'(1);
                        end else begin
                            col_cnt_d = '0;
                            str_cnt_d = '0;
                            row_cnt_d = row_max ? '0 : row_cnt_q + BITS_ROWS'(1);
                        end
                    end
                    if (cin_max && col_max && row_max) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            kw2_q     <= '0;
            sw_1_q    <= '0;
            cin_1_q   <= '0;
            cols_1_q  <= '0;
            rows_1_q  <= '0;
            end_col_q <= '0;
            cin_cnt_q <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            str_cnt_q <= '0;
            cfg_err_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_kw2_q   <= '0;
            m_sw_1_q  <= '0;
            m_flags_q <= '0;
        end else if (aclken) begin
            state_q   <= state_d;
            kw2_q     <= kw2_d;
            sw_1_q    <= sw_1_d;
            cin_1_q   <= cin_1_d;
            cols_1_q  <= cols_1_d;
            rows_1_q  <= rows_1_d;
            end_col_q <= end_col_d;
            cin_cnt_q <= cin_cnt_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            str_cnt_q <= str_cnt_d;
            cfg_err_q <= cfg_err_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_kw2_q   <= m_kw2_d;
            m_sw_1_q  <= m_sw_1_d;
            m_flags_q <= m_flags_d;
        end
    end

    assign cfg_err        = cfg_err_q;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;
    assign m_kw2          = m_kw2_q;
    assign m_sw_1         = m_sw_1_q;
    assign m_is_config    = m_flags_q[4];
    assign m_is_cin_last  = m_flags_q[3];
    assign m_is_cols_1_k2 = m_flags_q[2];
    assign m_is_col_valid = m_flags_q[1];
    assign m_last         = m_flags_q[0];

`ifdef CONV_TUSER_GEN_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            perf_q <= '0;
        end else if (aclken) begin
            if (cfg_accept) begin
                perf_q <= '0;
            end else if (m_valid_q && !m_ready && (perf_q != '1)) begin
                perf_q <= perf_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_tuser_gen.sv
// Scoreboard bench for conv_tuser_gen: stimulus pushes expected beats, a monitor pops and compares
// on every output handshake.
module tb_conv_tuser_gen;

    logic        aclk, aresetn, aclken;
    logic        cfg_valid, cfg_ready, cfg_err;
    logic [1:0]  cfg_kw2, cfg_sw_1;
    logic [9:0]  cfg_cin_1, cfg_cols_1, cfg_rows_1;
    logic        s_valid, s_ready;
    logic [63:0] s_data;
    logic        m_valid, m_ready;
    logic [63:0] m_data;
    logic [1:0]  m_kw2, m_sw_1;
    logic        m_is_config, m_is_cin_last, m_is_cols_1_k2, m_is_col_valid, m_last;
    logic [31:0] perf_stall_cnt;

    conv_tuser_gen #(
        .DATA_WIDTH(64), .BITS_KW2(2), .BITS_SW(2), .BITS_CIN(10), .BITS_COLS(10), .BITS_ROWS(10)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_kw2(cfg_kw2), .cfg_sw_1(cfg_sw_1),
        .cfg_cin_1(cfg_cin_1), .cfg_cols_1(cfg_cols_1), .cfg_rows_1(cfg_rows_1),
        .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_kw2(m_kw2), .m_sw_1(m_sw_1),
        .m_is_config(m_is_config), .m_is_cin_last(m_is_cin_last),
        .m_is_cols_1_k2(m_is_cols_1_k2), .m_is_col_valid(m_is_col_valid), .m_last(m_last),
        .perf_stall_cnt(perf_stall_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef logic [79:0] beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    frame_id = 0;

    function automatic beat_t mk(input logic [63:0] d, input int kw2, input int sw, input bit cfg,
                                 input bit cinl, input bit colk, input bit colv, input bit last);
        logic [1:0] k, s;
        k = kw2[1:0];
        s = sw[1:0];
        return beat_t'({d, k, s, cfg, cinl, colk, colv, last});
    endfunction

    function automatic beat_t cur_beat();
        return beat_t'({m_data, m_kw2, m_sw_1, m_is_config, m_is_cin_last, m_is_cols_1_k2,
                        m_is_col_valid, m_last});
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        beat_t act, exp;
        if (aresetn && aclken && m_valid && m_ready) begin
            act = cur_beat();
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat: got %h expected nothing (queue empty)", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL beat: got %h expected %h", act, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_cfg(input int kw2, input int sw, input int cin, input int cols,
                            input int rows, input bit reject);
        int n = 0;
        cfg_kw2 = kw2[1:0];
        cfg_sw_1 = sw[1:0];
        cfg_cin_1 = cin[9:0];
        cfg_cols_1 = cols[9:0];
        cfg_rows_1 = rows[9:0];
        cfg_valid = 1'b1;
        @(negedge aclk);
        while (!cfg_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL cfg_timeout: got cfg_ready=0 expected 1 within 200 cycles");
        end else if (!reject) begin
            sb.push_back(mk(64'd0, kw2, sw, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    // Expected flags come from the nested row/col/cin order and the column's stride phase.
    task automatic send_frame(input int kw2, input int sw, input int cin, input int cols,
                              input int rows, input int stop_after);
        int cnt = 0;
        frame_id++;
        for (int r = 0; r <= rows; r++) begin
            for (int c = 0; c <= cols; c++) begin
                for (int ci = 0; ci <= cin; ci++) begin
                    int n = 0;
                    if (stop_after >= 0 && cnt == stop_after) begin
                        s_valid = 1'b0;
                        return;
                    end
                    s_data = {16'hBEEF, 16'(frame_id), 32'(cnt)};
                    s_valid = 1'b1;
                    @(negedge aclk);
                    while (!s_ready && n < 200) begin
                        @(negedge aclk);
                        n++;
                    end
                    if (!s_ready) begin
                        checks++;
                        errors++;
                        $display("FAIL s_ready_timeout: got s_ready=0 expected 1 within 200");
                        s_valid = 1'b0;
                        return;
                    end
                    sb.push_back(mk(s_data, kw2, sw, 1'b0, ci == cin,
                                    (c == cols - kw2) && (kw2 != 0), (c % (sw + 1)) == 0,
                                    (r == rows) && (c == cols) && (ci == cin)));
                    tick();
                    cnt++;
                end
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t snap;
        int    exp_perf;
        aresetn = 1'b0;
        aclken = 1'b1;
        cfg_valid = 1'b0;
        cfg_kw2 = '0;
        cfg_sw_1 = '0;
        cfg_cin_1 = '0;
        cfg_cols_1 = '0;
        cfg_rows_1 = '0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_valid", 80'(m_valid), 80'd0);
        check("rst_beat", cur_beat(), 80'd0);
        check("rst_cfg_err", 80'(cfg_err), 80'd0);
        check("rst_perf", 80'(perf_stall_cnt), 80'd0);
        check("rst_s_ready", 80'(s_ready), 80'd0);
        tick();
        aresetn = 1'b1;
        tick();
        check("idle_cfg_ready", 80'(cfg_ready), 80'd1);

        // Basic frame: 2 cin x 4 cols x 1 row, kw2=1 so end column is 2
        send_cfg(1, 0, 1, 3, 0, 1'b0);
        send_frame(1, 0, 1, 3, 0, -1);
        repeat (3) tick();
        check("t1_idle_after", 80'(cfg_ready), 80'd1);
        check("t1_drained", 80'(sb.size()), 80'd0);

        // Stride 2: col_valid on even columns
        send_cfg(1, 1, 1, 3, 0, 1'b0);
        send_frame(1, 1, 1, 3, 0, -1);
        repeat (3) tick();

        // Rejected config stays idle and flags the error
        send_cfg(2, 0, 0, 1, 0, 1'b1);
        check("rej_cfg_err", 80'(cfg_err), 80'd1);
        check("rej_cfg_ready", 80'(cfg_ready), 80'd1);
        repeat (3) tick();
        check("rej_no_valid", 80'(m_valid), 80'd0);

        send_cfg(0, 0, 0, 2, 1, 1'b0);
        check("acc_cfg_err", 80'(cfg_err), 80'd0);
        send_frame(0, 0, 0, 2, 1, -1);
        repeat (3) tick();

        // Downstream stall of 5 cycles mid-frame
        send_cfg(1, 0, 2, 3, 1, 1'b0);
        fork
            send_frame(1, 0, 2, 3, 1, -1);
            begin
                repeat (8) @(posedge aclk);
                #1 m_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge aclk);
                    if (i == 0) begin
                        snap = cur_beat();
                        check("stall_valid", 80'(m_valid), 80'd1);
                    end else begin
                        check("stall_hold", cur_beat(), snap);
                    end
                    check("stall_s_ready", 80'(s_ready), 80'd0);
                end
                @(posedge aclk);
                #1 m_ready = 1'b1;
            end
        join
        repeat (3) tick();
`ifdef CONV_TUSER_GEN_PERF_EN
        exp_perf = 5;
`else
        exp_perf = 0;
`endif
        check("perf_stall", 80'(perf_stall_cnt), 80'(exp_perf));

        // Reset mid-frame, then a fresh frame must restart at col 0, cin 0
        send_cfg(1, 0, 1, 3, 0, 1'b0);
        send_frame(1, 0, 1, 3, 0, 3);
        aresetn = 1'b0;
        sb.delete();
        @(negedge aclk);
        check("mid_rst_valid", 80'(m_valid), 80'd0);
        check("mid_rst_idle", 80'(cfg_ready), 80'd1);
        check("mid_rst_s_ready", 80'(s_ready), 80'd0);
        tick();
        aresetn = 1'b1;
        tick();
        send_cfg(1, 0, 1, 3, 0, 1'b0);
        send_frame(1, 0, 1, 3, 0, -1);
        repeat (3) tick();

        // Clock enable low for 3 cycles mid-frame
        send_cfg(1, 1, 1, 3, 1, 1'b0);
        fork
            send_frame(1, 1, 1, 3, 1, -1);
            begin
                repeat (5) @(posedge aclk);
                #1 aclken = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge aclk);
                    if (i == 0) snap = cur_beat();
                    else check("en_hold", cur_beat(), snap);
                    check("en_s_ready", 80'(s_ready), 80'd0);
                    check("en_cfg_ready", 80'(cfg_ready), 80'd0);
                end
                @(posedge aclk);
                #1 aclken = 1'b1;
            end
        join
        repeat (5) tick();
        check("final_drained", 80'(sb.size()), 80'd0);
        check("final_idle", 80'(cfg_ready), 80'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
